// File: rtl/eight_dot_product_multiply_with_control_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eight_dot_product_multiply_with_control_pkg: widths, FSM states, masks   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package eight_dot_product_multiply_with_control_pkg;

   localparam int ELEMENT_WIDTH = 32;
   localparam int NO_OF_UNITS   = 8;
   localparam int VEC_WIDTH     = ELEMENT_WIDTH * NO_OF_UNITS;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   // Enable bits for the lanes that carry real elements: lanes [n-1:0].
   function automatic logic [NO_OF_UNITS-1:0] lane_mask_f(input int n);
      logic [NO_OF_UNITS-1:0] m;
      for (int i = 0; i < NO_OF_UNITS; i++) begin
         m[i] = (i < n);
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/eight_dot_product_multiply_with_control_dot8_lane_tree.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dot8_lane_tree: masked lane multipliers (stage 1) and adder tree (stage 2)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dot8_lane_tree #(
   parameter int ELEMENT_WIDTH = eight_dot_product_multiply_with_control_pkg::ELEMENT_WIDTH,
   parameter int NO_OF_UNITS   = eight_dot_product_multiply_with_control_pkg::NO_OF_UNITS
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   input  logic                                 in_first,
   input  logic                                 in_last,
   input  logic [NO_OF_UNITS-1:0]               lane_mask,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] a_vec,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] b_vec,
   output logic                                 sum_valid,
   output logic                                 sum_first,
   output logic                                 sum_last,
   output logic [ELEMENT_WIDTH-1:0]             sum
);

   logic [NO_OF_UNITS-1:0][ELEMENT_WIDTH-1:0] prod_d;
   logic [NO_OF_UNITS-1:0][ELEMENT_WIDTH-1:0] prod_q;
   logic                                      v1_q, first1_q, last1_q;
   logic [ELEMENT_WIDTH-1:0]                  tree_d;
   logic [ELEMENT_WIDTH-1:0]                  tree_q;
   logic                                      v2_q, first2_q, last2_q;

   // Low word of a signed product is the same as the unsigned one; keep only that.
   for (genvar k = 0; k < NO_OF_UNITS; k++) begin : g_lane
      assign prod_d[k] = lane_mask[k]
         ? ELEMENT_WIDTH'($signed(a_vec[k*ELEMENT_WIDTH +: ELEMENT_WIDTH]) *
                          $signed(b_vec[k*ELEMENT_WIDTH +: ELEMENT_WIDTH]))
         : '0;
   end

   always_comb begin
      tree_d = '0;
      for (int k = 0; k < NO_OF_UNITS; k++) begin
         tree_d = tree_d + prod_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q   <= '0;
         v1_q     <= 1'b0;
         first1_q <= 1'b0;
         last1_q  <= 1'b0;
         tree_q   <= '0;
         v2_q     <= 1'b0;
         first2_q <= 1'b0;
         last2_q  <= 1'b0;
      end else begin
         v1_q     <= in_valid;
         first1_q <= in_first;
         last1_q  <= in_last;
         if (in_valid) prod_q <= prod_d;
         v2_q     <= v1_q;
         first2_q <= first1_q;
         last2_q  <= last1_q;
         if (v1_q) tree_q <= tree_d;
      end
   end

   assign sum_valid = v2_q;
   assign sum_first = first2_q;
   assign sum_last  = last2_q;
   assign sum       = tree_q;

endmodule
`default_nettype wire

// File: rtl/eight_dot_product_multiply_with_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eight_dot_product_multiply_with_control: beat counter, FSM, accumulator  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module eight_dot_product_multiply_with_control #(
   parameter int NOE           = 16,
   parameter int ELEMENT_WIDTH = eight_dot_product_multiply_with_control_pkg::ELEMENT_WIDTH,
   parameter int NO_OF_UNITS   = eight_dot_product_multiply_with_control_pkg::NO_OF_UNITS
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] first_row_input,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] second_row_input,
   output logic [ELEMENT_WIDTH-1:0]             result,
   output logic                                 finish,
   input  logic                                 outsider_read_now
);

   import eight_dot_product_multiply_with_control_pkg::*;

   localparam int BEATS      = (NOE + NO_OF_UNITS - 1) / NO_OF_UNITS;
   localparam int LAST_LANES = NOE - NO_OF_UNITS * (BEATS - 1);
   localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0]       LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [NO_OF_UNITS-1:0] LAST_MASK = NO_OF_UNITS'(lane_mask_f(LAST_LANES));

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     finish_q, finish_d;
   logic [ELEMENT_WIDTH-1:0] acc_q, acc_d;
   logic                     done_q, done_d;

   logic                     accept;
   logic                     is_first;
   logic                     is_last;
   logic [NO_OF_UNITS-1:0]   lane_mask;
   logic                     sum_valid, sum_first, sum_last;
   logic [ELEMENT_WIDTH-1:0] sum;

   // Every state but DRAIN is ready for a beat; DONE accepting one starts a new operation.
   assign accept    = outsider_read_now && (state_q != ST_DRAIN);
   assign is_first  = (cnt_q == '0);
   assign is_last   = (cnt_q == LAST_BEAT);
   assign lane_mask = is_last ? LAST_MASK : '1;

   dot8_lane_tree #(
      .ELEMENT_WIDTH (ELEMENT_WIDTH),
      .NO_OF_UNITS   (NO_OF_UNITS)
   ) u_tree (
      .clk       (clk),
      .rst_n     (reset),
      .in_valid  (accept),
      .in_first  (is_first),
      .in_last   (is_last),
      .lane_mask (lane_mask),
      .a_vec     (first_row_input),
      .b_vec     (second_row_input),
      .sum_valid (sum_valid),
      .sum_first (sum_first),
      .sum_last  (sum_last),
      .sum       (sum)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      finish_d = finish_q;
      unique case (state_q)
         ST_IDLE, ST_COLLECT, ST_DONE: begin
            if (accept) begin
               finish_d = 1'b0;
               if (is_last) begin
                  cnt_d   = '0;
                  state_d = ST_DRAIN;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = ST_COLLECT;
               end
            end
         end
         ST_DRAIN: begin
            if (done_q) begin
               finish_d = 1'b1;
               state_d  = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Stage 3: the first partial sum of an operation reloads the accumulator.
   always_comb begin
      acc_d  = acc_q;
      done_d = sum_valid && sum_last;
      if (sum_valid) begin
         acc_d = sum_first ? sum : acc_q + sum;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         finish_q <= 1'b0;
         acc_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         finish_q <= finish_d;
         acc_q    <= acc_d;
         done_q   <= done_d;
      end
   end

   assign result = acc_q;
   assign finish = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_eight_dot_product_multiply_with_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_eight_dot_product_multiply_with_control: directed checks, NOE 16/12/8 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_eight_dot_product_multiply_with_control;

   logic         clk;
   logic         reset;
   logic [255:0] a_in, b_in;
   logic         rd;
   logic [31:0]  res16, res12, res8;
   logic         fin16, fin12, fin8;
   int           checks;
   int           errors;

   eight_dot_product_multiply_with_control #(.NOE(16)) u_dut16 (
      .clk (clk), .reset (reset), .first_row_input (a_in), .second_row_input (b_in),
      .result (res16), .finish (fin16), .outsider_read_now (rd));
   eight_dot_product_multiply_with_control #(.NOE(12)) u_dut12 (
      .clk (clk), .reset (reset), .first_row_input (a_in), .second_row_input (b_in),
      .result (res12), .finish (fin12), .outsider_read_now (rd));
   eight_dot_product_multiply_with_control #(.NOE(8)) u_dut8 (
      .clk (clk), .reset (reset), .first_row_input (a_in), .second_row_input (b_in),
      .result (res8), .finish (fin8), .outsider_read_now (rd));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; presents one beat for the next posedge and returns at the following negedge.
   task automatic beat_vec(input logic [255:0] a, input logic [255:0] b);
      a_in = a;
      b_in = b;
      rd   = 1'b1;
      @(negedge clk);
      rd   = 1'b0;
   endtask

   task automatic beat(input logic [31:0] a, input logic [31:0] b);
      beat_vec({8{a}}, {8{b}});
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      rd    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (fin16 !== 1'b0 || fin12 !== 1'b0 || fin8 !== 1'b0) begin
         errors++;
         $display("FAIL reset_finish: got %b%b%b required 000", fin16, fin12, fin8);
      end
      checks++;
      if (res16 !== 32'd0 || res12 !== 32'd0 || res8 !== 32'd0) begin
         errors++;
         $display("FAIL reset_result: got %h %h %h required 0", res16, res12, res8);
      end
      reset = 1'b1;
   endtask

   task automatic test_back_to_back_beats();
      logic exp;
      apply_reset();
      beat(32'd1, 32'd2);
      beat(32'd3, 32'd1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         exp = (k == 3);
         checks++;
         if (fin16 !== exp) begin
            errors++;
            $display("FAIL b2b_finish_c%0d: got %b required %b", k, fin16, exp);
         end
      end
      checks++;
      if (res16 !== 32'd40) begin
         errors++;
         $display("FAIL b2b_result: got %0d required 40", res16);
      end
   endtask

   task automatic test_stall();
      logic exp;
      apply_reset();
      beat(32'd1, 32'd2);
      @(negedge clk);
      checks++;
      if (fin16 !== 1'b0) begin
         errors++;
         $display("FAIL stall_gap_finish: got %b required 0", fin16);
      end
      beat(32'd3, 32'd1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         exp = (k == 3);
         checks++;
         if (fin16 !== exp) begin
            errors++;
            $display("FAIL stall_finish_c%0d: got %b required %b", k, fin16, exp);
         end
      end
      checks++;
      if (res16 !== 32'd40) begin
         errors++;
         $display("FAIL stall_result: got %0d required 40", res16);
      end
   endtask

   task automatic test_mask();
      logic [255:0] va, vb;
      logic         exp;
      apply_reset();
      beat(32'd1, 32'd1);
      for (int l = 0; l < 8; l++) begin
         va[l*32 +: 32] = (l < 4) ? 32'd1 : 32'd7;
         vb[l*32 +: 32] = (l < 4) ? 32'd1 : 32'd9;
      end
      beat_vec(va, vb);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         exp = (k == 3);
         checks++;
         if (fin12 !== exp) begin
            errors++;
            $display("FAIL mask_finish_c%0d: got %b required %b", k, fin12, exp);
         end
      end
      checks++;
      if (res12 !== 32'd12) begin
         errors++;
         $display("FAIL mask_result: got %0d required 12", res12);
      end
   endtask

   task automatic test_signed_wrap();
      logic exp;
      apply_reset();
      beat(32'hFFFF_FFFE, 32'd5);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         exp = (k == 3);
         checks++;
         if (fin8 !== exp) begin
            errors++;
            $display("FAIL signed_finish_c%0d: got %b required %b", k, fin8, exp);
         end
      end
      checks++;
      if (res8 !== 32'hFFFF_FFB0) begin
         errors++;
         $display("FAIL signed_result: got %h required ffffffb0", res8);
      end
      beat(32'h0001_0000, 32'h0001_0000);
      checks++;
      if (fin8 !== 1'b0) begin
         errors++;
         $display("FAIL wrap_finish_drop: got %b required 0", fin8);
      end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         exp = (k == 3);
         checks++;
         if (fin8 !== exp) begin
            errors++;
            $display("FAIL wrap_finish_c%0d: got %b required %b", k, fin8, exp);
         end
      end
      checks++;
      if (res8 !== 32'd0) begin
         errors++;
         $display("FAIL wrap_result: got %h required 0", res8);
      end
   endtask

   task automatic test_reset_mid_op();
      logic exp;
      apply_reset();
      beat(32'd5, 32'd5);
      reset = 1'b0;
      a_in  = {8{32'd9}};
      b_in  = {8{32'd9}};
      rd    = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++;
         if (fin16 !== 1'b0 || res16 !== 32'd0) begin
            errors++;
            $display("FAIL midreset_hold_c%0d: got finish %b result %0d required 0 0", k, fin16, res16);
         end
      end
      rd    = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      beat(32'd1, 32'd1);
      beat(32'd1, 32'd1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         exp = (k == 3);
         checks++;
         if (fin16 !== exp) begin
            errors++;
            $display("FAIL midreset_finish_c%0d: got %b required %b", k, fin16, exp);
         end
      end
      checks++;
      if (res16 !== 32'd16) begin
         errors++;
         $display("FAIL midreset_result: got %0d required 16", res16);
      end
   endtask

   task automatic test_back_to_back_ops();
      logic exp;
      beat(32'd2, 32'd2);
      checks++;
      if (fin16 !== 1'b0) begin
         errors++;
         $display("FAIL b2bop_finish_drop: got %b required 0", fin16);
      end
      beat(32'd1, 32'd1);
      a_in = {8{32'd100}};
      b_in = {8{32'd100}};
      rd   = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         exp = (k == 3);
         checks++;
         if (fin16 !== exp) begin
            errors++;
            $display("FAIL b2bop_finish_c%0d: got %b required %b", k, fin16, exp);
         end
      end
      rd = 1'b0;
      checks++;
      if (res16 !== 32'd40) begin
         errors++;
         $display("FAIL b2bop_result: got %0d required 40", res16);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (fin16 !== 1'b1 || res16 !== 32'd40) begin
         errors++;
         $display("FAIL b2bop_hold: got finish %b result %0d required 1 40", fin16, res16);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      rd     = 1'b0;
      a_in   = '0;
      b_in   = '0;
      test_reset();
      test_back_to_back_beats();
      test_stall();
      test_mask();
      test_signed_wrap();
      test_reset_mid_op();
      test_back_to_back_ops();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
